// File: rtl/cpu_pkg.sv
// Shared load/store definitions: funct3 size codes, LSU FSM state
// encoding and the request legality rule.
package cpu_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ACC1 = 3'd1;
   localparam logic [2:0] ACC2 = 3'd2;
   localparam logic [2:0] WAIT = 3'd3;
   localparam logic [2:0] RESP = 3'd4;

   // Exactly one of rd/wr; stores have no unsigned variants.
   function automatic logic req_legal(input logic       rd,
                                      input logic       wr,
                                      input logic [2:0] sz);
      logic ok;
      ok = 1'b0;
      if (rd && !wr)
         ok = (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) ||
              (sz == SZ_BU) || (sz == SZ_HU);
      else if (wr && !rd)
         ok = (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W);
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the data port.
// In: off_i, size_i, wdata_i, lo_i/hi_i. Out: split_o, be1_o/be2_o,
// wlo_o/whi_o (lane-shifted store words), ldata_o (extended load).
module lsu_align
   import cpu_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [2:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic        split_o,
   output logic [3:0]  be1_o,
   output logic [3:0]  be2_o,
   output logic [31:0] wlo_o,
   output logic [31:0] whi_o,
   output logic [31:0] ldata_o
);

   logic [3:0]  mask;
   logic [2:0]  nbytes;
   logic [7:0]  mask64;
   logic [63:0] w64;
   logic [63:0] d64;
   logic [31:0] d;
   logic        unused_d64;

   always_comb begin
      mask   = 4'b1111;
      nbytes = 3'd4;
      case (size_i[1:0])
         2'b00: begin
            mask   = 4'b0001;
            nbytes = 3'd1;
         end
         2'b01: begin
            mask   = 4'b0011;
            nbytes = 3'd2;
         end
         default: ;
      endcase
   end

   assign split_o = ({2'b00, off_i} + {1'b0, nbytes}) > 4'd4;
   assign mask64  = {4'b0000, mask} << off_i;
   assign be1_o   = mask64[3:0];
   assign be2_o   = mask64[7:4];

   assign w64   = {32'd0, wdata_i} << {off_i, 3'b000};
   assign wlo_o = w64[31:0];
   assign whi_o = w64[63:32];

   assign d64 = {hi_i, lo_i} >> {off_i, 3'b000};
   assign d   = d64[31:0];
   assign unused_d64 = &{1'b0, d64[63:32]};

   always_comb begin
      ldata_o = d;
      case (size_i)
         SZ_B:  ldata_o = {{24{d[7]}}, d[7:0]};
         SZ_H:  ldata_o = {{16{d[15]}}, d[15:0]};
         SZ_BU: ldata_o = {24'd0, d[7:0]};
         SZ_HU: ldata_o = {16'd0, d[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_port.sv
// Load/store port onto a word-wide synchronous SRAM (1-cycle reads).
// Ports: req_* from decoder/ALU, busy/done/err/rdata to core, mem_* to SRAM.
module data_mem_port
   import cpu_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int ADDR_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_rd_en,
   input  logic                  req_wr_en,
   input  logic [2:0]            req_size,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   localparam logic [DEPTH_LOG2-1:0] ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   logic [2:0]            state_q, state_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            off_q, off_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [DEPTH_LOG2-1:0] word_q, word_d;
   logic [31:0]           lo_q, lo_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [3:0]            mem_be_q, mem_be_d;
   logic [DEPTH_LOG2-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;

   logic                  idle;
   logic [1:0]            a_off;
   logic [2:0]            a_size;
   logic [31:0]           a_wdata;
   logic [31:0]           a_lo;
   logic                  a_split;
   logic [3:0]            a_be1, a_be2;
   logic [31:0]           a_wlo, a_whi;
   logic [31:0]           a_ldata;
   logic [DEPTH_LOG2-1:0] req_word;
   logic                  unused_addr;

   assign idle     = (state_q == IDLE);
   assign req_word = req_addr[DEPTH_LOG2+1:2];
   assign unused_addr = &{1'b0, req_addr[ADDR_W-1:DEPTH_LOG2+2]};

   // Aligner sees the live request while idle, latched fields afterwards.
   assign a_off   = idle ? req_addr[1:0] : off_q;
   assign a_size  = idle ? req_size      : size_q;
   assign a_wdata = idle ? req_wdata     : wdata_q;
   // Split loads finish with the high word on mem_rdata; lo was buffered.
   assign a_lo    = a_split ? lo_q : mem_rdata;

   lsu_align u_align (
      .off_i   (a_off),
      .size_i  (a_size),
      .wdata_i (a_wdata),
      .lo_i    (a_lo),
      .hi_i    (mem_rdata),
      .split_o (a_split),
      .be1_o   (a_be1),
      .be2_o   (a_be2),
      .wlo_o   (a_wlo),
      .whi_o   (a_whi),
      .ldata_o (a_ldata)
   );

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      err_d       = err_q;
      size_d      = size_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      word_d      = word_q;
      lo_d        = lo_q;
      rdata_d     = rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_be_d    = 4'b0000;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_rd_en || req_wr_en) begin
               wr_d    = req_wr_en;
               size_d  = req_size;
               off_d   = req_addr[1:0];
               wdata_d = req_wdata;
               word_d  = req_word;
               if (req_legal(req_rd_en, req_wr_en, req_size)) begin
                  err_d       = 1'b0;
                  mem_en_d    = 1'b1;
                  mem_we_d    = req_wr_en;
                  mem_be_d    = a_be1;
                  mem_addr_d  = req_word;
                  mem_wdata_d = a_wlo;
                  state_d     = ACC1;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ACC1: begin
            if (a_split) begin
               mem_en_d    = 1'b1;
               mem_we_d    = wr_q;
               mem_be_d    = a_be2;
               mem_addr_d  = word_q + ONE;
               mem_wdata_d = a_whi;
               state_d     = ACC2;
            end else begin
               state_d = wr_q ? RESP : WAIT;
            end
         end
         ACC2: begin
            if (!wr_q)
               lo_d = mem_rdata;
            state_d = wr_q ? RESP : WAIT;
         end
         WAIT: begin
            rdata_d = a_ldata;
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         size_q      <= 3'd0;
         off_q       <= 2'd0;
         wdata_q     <= 32'd0;
         word_q      <= '0;
         lo_q        <= 32'd0;
         rdata_q     <= 32'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'b0000;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
         size_q      <= size_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         word_q      <= word_d;
         lo_q        <= lo_d;
         rdata_q     <= rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign busy      = !idle;
   assign done      = (state_q == RESP);
   assign err       = done && err_q;
   assign rdata     = rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboard bench for data_mem_port: byte-level reference memory,
// expected beats and completions queued at issue, checked by a monitor.
module tb_data_mem_port;

   localparam int DL = 10;
   localparam int NBYTES = 4 << DL;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_rd_en = 1'b0;
   logic          req_wr_en = 1'b0;
   logic [2:0]    req_size = 3'd0;
   logic [31:0]   req_addr = 32'd0;
   logic [31:0]   req_wdata = 32'd0;
   logic          busy, done, err;
   logic [31:0]   rdata;
   logic          mem_en, mem_we;
   logic [3:0]    mem_be;
   logic [DL-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = 32'd0;

   data_mem_port #(.DEPTH_LOG2(DL), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_rd_en (req_rd_en),
      .req_wr_en (req_wr_en),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM behavioural model
   logic [31:0] sram [0:(1<<DL)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int l = 0; l < 4; l++)
               if (mem_be[l]) sram[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          issue;
   } exp_t;

   typedef struct {
      logic [DL-1:0] addr;
      logic          we;
      logic [3:0]    be;
      logic [31:0]   wdata;
   } beat_t;

   exp_t  expq[$];
   beat_t beatq[$];
   logic [7:0]  refm [0:NBYTES-1];
   logic [31:0] last_rdata = 32'd0;
   int checks = 0;
   int fails  = 0;

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   endtask

   // Monitor: bus beats and completions
   always @(negedge clk) begin : mon
      beat_t b;
      exp_t  e;
      if (rst_n) begin
         if (mem_en) begin
            checks++;
            if (beatq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_beat: addr %0d be %b", mem_addr, mem_be);
            end else begin
               b = beatq.pop_front();
               if (mem_addr !== b.addr || mem_we !== b.we || mem_be !== b.be ||
                   (b.we && ((mem_wdata ^ b.wdata) & lane_mask(b.be)) != 0)) begin
                  fails++;
                  $display("FAIL beat: got a=%0d we=%b be=%b wd=%h want a=%0d we=%b be=%b wd=%h",
                           mem_addr, mem_we, mem_be, mem_wdata,
                           b.addr, b.we, b.be, b.wdata);
               end
            end
         end
         if (done) begin
            checks++;
            if (expq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done");
            end else begin
               e = expq.pop_front();
               if (err !== e.err || rdata !== e.rdata || (cyc - e.issue) != e.lat) begin
                  fails++;
                  $display("FAIL resp: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                           err, rdata, cyc - e.issue, e.err, e.rdata, e.lat);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while ((busy || done) && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (busy || done) begin
         fails++;
         $display("FAIL idle_timeout: busy=%b", busy);
         finish_test();
      end
   endtask

   // Reference model: byte-addressed memory, wraps at its size.
   task automatic do_op(input logic rd, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
      int nb, lat, t, p, w1, ln;
      logic legal, split;
      logic [31:0] v;
      beat_t b1, b2;
      exp_t e;
      wait_idle();
      legal = (rd ^ wr) &&
              (rd ? (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                  : (sz inside {3'd0, 3'd1, 3'd2}));
      nb = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
      lat = 1;
      if (legal) begin
         p = int'(a % NBYTES);
         split = ((p % 4) + nb) > 4;
         lat = (wr ? 2 : 3) + (split ? 1 : 0);
         w1 = p / 4;
         b1 = '{addr: DL'(w1), we: wr, be: 4'b0, wdata: 32'd0};
         b2 = '{addr: DL'((w1 + 1) % (1 << DL)), we: wr, be: 4'b0, wdata: 32'd0};
         v = 32'd0;
         for (int i = 0; i < nb; i++) begin
            p = int'((a + i) % NBYTES);
            ln = p % 4;
            if (p / 4 == w1) begin
               b1.be[ln] = 1'b1;
               b1.wdata[8*ln +: 8] = wd[8*i +: 8];
            end else begin
               b2.be[ln] = 1'b1;
               b2.wdata[8*ln +: 8] = wd[8*i +: 8];
            end
            if (wr) refm[p] = wd[8*i +: 8];
            else    v[8*i +: 8] = refm[p];
         end
         beatq.push_back(b1);
         if (split) beatq.push_back(b2);
         if (rd) begin
            if (sz == 3'd0)      v = {{24{v[7]}}, v[7:0]};
            else if (sz == 3'd1) v = {{16{v[15]}}, v[15:0]};
            last_rdata = v;
         end
      end
      e = '{err: !legal, rdata: last_rdata, lat: lat, issue: cyc};
      expq.push_back(e);
      req_rd_en = rd;
      req_wr_en = wr;
      req_size  = sz;
      req_addr  = a;
      req_wdata = wd;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 20);
      if (!done) begin
         fails++;
         $display("FAIL done_timeout: op addr %h", a);
         finish_test();
      end
      req_rd_en = 1'b0;
      req_wr_en = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_ctl"}, {26'd0, done, err, mem_en, mem_we, mem_be == 4'd0 ? 1'b0 : 1'b1,
                         mem_addr == '0 ? 1'b0 : 1'b1}, 32'd0);
      chk({nm, "_rdata"}, rdata, 32'd0);
      chk({nm, "_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic rd, wr;
      for (int i = 0; i < NBYTES; i++) refm[i] = 8'($urandom);
      for (int w = 0; w < (1 << DL); w++)
         sram[w] = {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]};

      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Aligned store, then sub-word loads of it
      do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      do_op(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
      chk("lb_0x13", rdata, 32'hFFFFFFDE);
      do_op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
      chk("lbu_0x13", rdata, 32'h000000DE);
      do_op(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
      chk("lh_0x12", rdata, 32'hFFFFDEAD);

      // Split word load across words 3/4
      do_op(1'b0, 1'b1, 3'b010, 32'h0C, 32'h44332211);
      do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'h88776655);
      do_op(1'b1, 1'b0, 3'b010, 32'h0E, 32'h0);
      chk("lw_split", rdata, 32'h66554433);

      // Split half store
      do_op(1'b0, 1'b1, 3'b001, 32'h0F, 32'h0000ABCD);
      do_op(1'b1, 1'b0, 3'b001, 32'h0F, 32'h0);
      chk("lh_split", rdata, 32'hFFFFABCD);
      do_op(1'b1, 1'b0, 3'b101, 32'h0F, 32'h0);
      chk("lhu_split", rdata, 32'h0000ABCD);

      // Illegal requests leave rdata alone
      do_op(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
      do_op(1'b1, 1'b1, 3'b010, 32'h10, 32'h12345678);
      chk("err_rdata_hold", rdata, 32'h0000ABCD);
      do_op(1'b0, 1'b1, 3'b100, 32'h10, 32'h12345678);

      // Top-word wrap
      do_op(1'b1, 1'b0, 3'b010, 32'hFFE, 32'h0);
      do_op(1'b0, 1'b1, 3'b010, 32'hFFD, 32'hA1B2C3D4);
      do_op(1'b1, 1'b0, 3'b010, 32'hFFD, 32'h0);
      chk("lw_wrap", rdata, 32'hA1B2C3D4);

      // Reset during beat 2 of a split store: only beat 1 lands
      wait_idle();
      beatq.push_back('{addr: DL'(8), we: 1'b1, be: 4'b1110, wdata: 32'h22334400});
      beatq.push_back('{addr: DL'(9), we: 1'b1, be: 4'b0001, wdata: 32'h00000011});
      refm[32'h21] = 8'h44;
      refm[32'h22] = 8'h33;
      refm[32'h23] = 8'h22;
      req_wr_en = 1'b1;
      req_size  = 3'b010;
      req_addr  = 32'h21;
      req_wdata = 32'h11223344;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("mid_reset");
      req_wr_en = 1'b0;
      last_rdata = 32'd0;
      @(negedge clk);
      chk_zero("reset_hold");
      rst_n = 1'b1;
      do_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
      do_op(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         rd = (r == 0) || (r < 5);
         wr = (r == 0) || (r >= 5);
         do_op(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom);
      end

      wait_idle();
      @(negedge clk);
      chk("expq_drained", expq.size(), 32'd0);
      chk("beatq_drained", beatq.size(), 32'd0);
      finish_test();
   end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
Load/store responder on the consuming end of the decoder's memory controls (data_read_en, data_write_en, data_size = funct3). It takes a byte address from the ALU and store data from rs2, and drives a word-wide synchronous SRAM with one-cycle read latency. It handles byte, half and word sizes, sign/zero extension, and misaligned accesses that cross a word boundary (split into two beats). It returns load data to the rd write-back mux and stalls the core while busy.

Parameters:
DEPTH_LOG2, 10, log2 of SRAM depth in 32-bit words; word address is addr[DEPTH_LOG2+1:2] and wraps modulo depth.
ADDR_W, 32, width of the core byte address.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_rd_en  in  1  load request (data_read_en)
req_wr_en  in  1  store request (data_write_en)
req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address from ALU
req_wdata  in  32  store data, right-justified
busy  out  1  core stall; high whenever state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; illegal request
rdata  out  32  extended load data; holds value until next load done
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write
mem_be  out  4  SRAM byte enables
mem_addr  out  DEPTH_LOG2  SRAM word address
mem_wdata  out  32  lane-aligned write data
mem_rdata  in  32  SRAM read data, valid the cycle after the mem_en read

Behaviour:
- Reset: async on rst_n low. State goes to IDLE. busy, done, err, mem_en, mem_we, mem_be, mem_addr, mem_wdata and rdata all go to 0. All mem_* outputs are registered.
- Core holds the req_* inputs stable from acceptance until done. The IDLE cycle after RESP samples a fresh request.
- Legality: exactly one of rd/wr must be high. Legal load sizes are 000, 001, 010, 100, 101. Legal store sizes are 000, 001, 010. Anything else produces no mem_en, then RESP with err=1.
- nbytes = 1/2/4 by size[1:0]; off = addr[1:0]; split = (off + nbytes > 4).
- Lanes: mask64 = byte-mask << off. be1 = mask64[3:0], be2 = mask64[7:4]. wdata64 = req_wdata << 8*off; beat1 takes the low word, beat2 the high word.
- FSM:
  - IDLE: legal request: latch fields, load beat-1 mem_* (word addr W), go to ACC1. Illegal: go to RESP with err. No request: stay.
  - ACC1: beat 1 on the bus. If split, load beat 2 (addr W+1 mod depth) and go to ACC2. Else load go to WAIT; store go to RESP.
  - ACC2: beat 2 on the bus. Capture mem_rdata into lo_buf (load). Load go to WAIT; store go to RESP.
  - WAIT: mem_en=0. Capture the last mem_rdata. Assemble {hi,lo} >> 8*off, truncate to nbytes, sign-extend for 000/001, zero-extend for 100/101/010. Write rdata. Go to RESP.
  - RESP: done=1 for one cycle, err as latched; go to IDLE.
- mem_en/mem_we are high only in ACC1/ACC2. mem_we equals the latched wr_en.
- Latency from the request cycle to done: aligned store 2, split store 3, aligned load 3, split load 4, illegal 1.
- Word address W+1 at the top word wraps to word 0.
- Reset mid-operation aborts immediately. For a split store, beat 1 may already be written; this is accepted. No beat issues after reset.
- rdata is unchanged by stores and by err completions.

Decomposition:
- Shared package cpu_pkg: funct3 size constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the FSM state encoding (IDLE, ACC1, ACC2, WAIT, RESP).
- One combinational sub-module, lsu_align. It computes split, be1/be2, the shifted write words, and the load extract/extend from {hi,lo}, off and size.

Test Plan:
1. SW addr 0x10, wdata 0xDEADBEEF -> ACC1: mem_addr=4, be=1111, we=1, wdata 0xDEADBEEF; done at cycle 2, err=0.
2. Word 4 = 0xDEADBEEF; LB addr 0x13 -> rdata 0xFFFFFFDE, done at cycle 3. LBU -> 0x000000DE. LH addr 0x12 -> 0xFFFFDEAD.
3. Word3 = 0x44332211, word4 = 0x88776655; LW addr 0x0E -> beats at addr 3 then 4, rdata 0x66554433, done at cycle 4.
4. SH addr 0x0F, wdata 0x0000ABCD -> beat 1: addr 3, be 1000, wdata[31:24]=CD. Beat 2: addr 4, be 0001, wdata[7:0]=AB. Done at cycle 3.
5. Illegal requests: load size 011 -> done+err at cycle 1, mem_en never high. rd&wr both high -> err, rdata unchanged.
6. Wrap and reset: LW addr 0xFFE (DEPTH_LOG2=10) -> beats at words 1023 and 0. Split SW with rst_n low during ACC2 -> all outputs 0 immediately, IDLE, no beat 2.
